// File: rtl/ch1_frame_ctrl.sv
// Channel 1 sequencing: 512 Hz frame sequencer, length counter,
// sweep/envelope pace timers, restart sequencing and active flag.
// Ports:
//   dyfa_1mhz/apu_reset   clock, sync active-high reset
//   apu_en, div_tick      master enable, 512 Hz tick
//   trig, len_*           FF14 trigger, FF11 length load
//   sweep_pace, env_pace  pace fields
//   dac_on, sweep_ovf     active-flag clear sources
//   seq_step              frame-sequencer step
//   ch1_restart           restart pulse
//   sweep_step, env_step  datapath step pulses
//   ch1_active, len_left  NR52 bit 0 and remaining length
module ch1_frame_ctrl (
  input  logic       dyfa_1mhz,
  input  logic       apu_reset,
  input  logic       apu_en,
  input  logic       div_tick,
  input  logic       trig,
  input  logic       len_en,
  input  logic       len_wr,
  input  logic [5:0] len_data,
  input  logic [2:0] sweep_pace,
  input  logic [2:0] env_pace,
  input  logic       dac_on,
  input  logic       sweep_ovf,
  output logic [2:0] seq_step,
  output logic       ch1_restart,
  output logic       sweep_step,
  output logic       env_step,
  output logic       ch1_active,
  output logic [6:0] len_left
);

  logic [2:0] s_q, s_d;
  logic       len_clk_q, len_clk_d;
  logic       swp_clk_q, swp_clk_d;
  logic       env_clk_q, env_clk_d;
  logic       rst_q, rst_d;
  logic       swp_stp_q, swp_stp_d;
  logic       env_stp_q, env_stp_d;
  logic       act_q, act_d;
  logic [6:0] len_q, len_d;
  logic [3:0] swp_t_q, swp_t_d;
  logic [3:0] env_t_q, env_t_d;

  logic       go;
  logic       len_dec;
  logic       expire;
  logic [3:0] swp_rld;
  logic [3:0] env_rld;

  assign swp_rld = (sweep_pace == 3'd0) ? 4'd8 : {1'b0, sweep_pace};
  assign env_rld = (env_pace == 3'd0) ? 4'd8 : {1'b0, env_pace};

  // Restart actions happen on the edge that samples trig,
  // the same edge on which ch1_restart rises.
  assign go      = trig & apu_en;
  assign len_dec = len_clk_q & len_en & apu_en;
  assign expire  = ~len_wr & len_dec & (len_q == 7'd1);

  always_comb begin
    s_d       = s_q;
    len_clk_d = 1'b0;
    swp_clk_d = 1'b0;
    env_clk_d = 1'b0;
    rst_d     = 1'b0;
    swp_stp_d = 1'b0;
    env_stp_d = 1'b0;
    swp_t_d   = swp_t_q;
    env_t_d   = env_t_q;
    if (apu_en) begin
      rst_d = trig;
      if (div_tick) begin
        s_d       = s_q + 3'd1;
        len_clk_d = ~s_q[0];
        swp_clk_d = (s_q[1:0] == 2'b10);
        env_clk_d = (s_q == 3'd7);
      end
      if (trig) begin
        swp_t_d = swp_rld;
      end else if (swp_clk_q) begin
        if (swp_t_q > 4'd1) begin
          swp_t_d = swp_t_q - 4'd1;
        end else begin
          swp_t_d   = swp_rld;
          swp_stp_d = (sweep_pace != 3'd0);
        end
      end
      if (trig) begin
        env_t_d = env_rld;
      end else if (env_clk_q) begin
        if (env_t_q > 4'd1) begin
          env_t_d = env_t_q - 4'd1;
        end else begin
          env_t_d   = env_rld;
          env_stp_d = (env_pace != 3'd0);
        end
      end
    end else begin
      s_d = 3'd0;
    end
  end

  // Length: a write wins; otherwise reload-if-zero on restart,
  // else decrement on a length clock.
  always_comb begin
    len_d = len_q;
    if (len_wr) begin
      len_d = 7'd64 - {1'b0, len_data};
    end else if (go && len_q == 7'd0) begin
      len_d = 7'd64;
    end else if (len_dec && len_q != 7'd0) begin
      len_d = len_q - 7'd1;
    end
  end

  always_comb begin
    act_d = act_q;
    if (!apu_en) begin
      act_d = 1'b0;
    end else if (trig) begin
      act_d = dac_on;
    end else if (!dac_on || sweep_ovf || expire) begin
      act_d = 1'b0;
    end
  end

  always_ff @(posedge dyfa_1mhz) begin
    if (apu_reset) begin
      s_q       <= 3'd0;
      len_clk_q <= 1'b0;
      swp_clk_q <= 1'b0;
      env_clk_q <= 1'b0;
      rst_q     <= 1'b0;
      swp_stp_q <= 1'b0;
      env_stp_q <= 1'b0;
      act_q     <= 1'b0;
      len_q     <= 7'd0;
      swp_t_q   <= 4'd0;
      env_t_q   <= 4'd0;
    end else begin
      s_q       <= s_d;
      len_clk_q <= len_clk_d;
      swp_clk_q <= swp_clk_d;
      env_clk_q <= env_clk_d;
      rst_q     <= rst_d;
      swp_stp_q <= swp_stp_d;
      env_stp_q <= env_stp_d;
      act_q     <= act_d;
      len_q     <= len_d;
      swp_t_q   <= swp_t_d;
      env_t_q   <= env_t_d;
    end
  end

  assign seq_step    = s_q;
  assign ch1_restart = rst_q;
  assign sweep_step  = swp_stp_q;
  assign env_step    = env_stp_q;
  assign ch1_active  = act_q;
  assign len_left    = len_q;

endmodule

// File: doc/ch1_frame_ctrl.md
# ch1_frame_ctrl

Synchronous controller that sequences the channel 1 datapath. It contains the 512 Hz frame sequencer and derives the length (256 Hz), sweep (128 Hz) and envelope (64 Hz) clocks from it. It also owns the channel 1 length counter, sweep-pace timer, envelope-pace timer, the trigger-to-restart sequencing and the channel-active flag. It sits between the register file (FF10–FF14, FF26) and the channel 1 frequency/sweep/envelope/duty datapath.

## Interface
Parameters: none.
- dyfa_1mhz  in  1  clock; all state updates on rising edge
- apu_reset  in  1  synchronous, active-high reset
- apu_en  in  1  FF26 bit 7; 0 holds sequencer idle
- div_tick  in  1  one-cycle pulse, 512 Hz
- trig  in  1  one-cycle pulse: FF14 write with d[7]=1
- len_en  in  1  FF14 d6
- len_wr  in  1  one-cycle pulse: FF11 write
- len_data  in  6  FF11 d[5:0]
- sweep_pace  in  3  FF10 d[6:4]
- env_pace  in  3  FF12 d[2:0]
- dac_on  in  1  FF12 d[7:3] != 0
- sweep_ovf  in  1  overflow flag from the frequency datapath
- seq_step  out  3  frame-sequencer step
- ch1_restart  out  1  one-cycle restart pulse
- sweep_step  out  1  one-cycle: apply one sweep iteration
- env_step  out  1  one-cycle: apply one envelope step
- ch1_active  out  1  channel enabled (NR52 bit 0)
- len_left  out  7  remaining length ticks, 0..64

## Operation
- Frame sequencer: 3-bit step s. On div_tick with apu_en=1, s <= s+1 (mod 8). Internal pulses are registered from the old s one cycle after div_tick:
  - len_clk for s in {0,2,4,6}
  - swp_clk for s in {2,6}
  - env_clk for s = 7
- apu_en=0 forces s=0, suppresses all pulses and clears ch1_active. len_left is retained.
- Restart: trig in cycle n produces ch1_restart high in cycle n+1 only. Back-to-back trig gives back-to-back pulses.
- On ch1_restart:
  - sweep timer <= (sweep_pace==0 ? 8 : sweep_pace)
  - env timer <= (env_pace==0 ? 8 : env_pace)
  - if len_left==0 then len_left <= 64
  - ch1_active <= dac_on
- Length counter:
  - len_wr: len_left <= 64 - len_data (range 1..64).
  - len_clk with len_en=1 and len_left!=0: len_left decrements. The transition 1->0 clears ch1_active in the same edge.
  - len_en=0: no decrement.
  - len_wr and len_clk in the same cycle: the write wins.
- Sweep timer (4-bit):
  - On swp_clk, if timer>1 it decrements.
  - Otherwise it reloads (pace==0 ? 8 : pace). sweep_step pulses the next cycle only when sweep_pace!=0.
- Envelope timer: identical mechanism, driven by env_clk and env_pace, producing env_step.
- ch1_active clear sources, all taking effect on the next edge:
  - apu_reset
  - apu_en=0
  - dac_on=0
  - sweep_ovf=1
  - length expiry
- Priority: ch1_restart with dac_on=1 sets ch1_active and overrides same-cycle sweep_ovf and length expiry. apu_reset and apu_en=0 override everything.
- Restart coincident with len_clk: the reload-if-zero applies first. If len_left was nonzero, the decrement still applies.
- Restart coincident with swp_clk or env_clk: the reload wins, and no step pulse is issued.

## Timing
- Reset: every output is 0 one edge after apu_reset is sampled high; internal timers are 0.
- div_tick at n:
  - len/swp/env internal clocks high at n+1.
  - sweep_step/env_step high at n+2.
  - seq_step updated at n+1.
- trig at n: ch1_restart and ch1_active update at n+1.
- All output pulses are exactly one cycle wide. There are no combinational input-to-output paths.
- div_tick asserted during reset is ignored.
- Reset mid-sequence restarts at s=0, and the next div_tick makes s=1.

## Test plan
- Reset, then 8 div_ticks with apu_en=1 -> seq_step 1..7,0; len_clk 4×, swp_clk 2×, env_clk 1×; each internal pulse 1 cycle after its tick.
- len_wr data=62 (len_left=2), len_en=1, dac_on=1, trig -> ch1_active=1; after 2 len_clk, len_left=0 and ch1_active=0 at that edge.
- len_left=0, trig -> len_left=64 on the restart edge; trig coincident with len_clk -> 64 then no decrement that edge.
- sweep_pace=3, trig, 12 swp_clk -> sweep_step pulses on the 3rd, 6th, 9th and 12th; sweep_pace=0 -> none.
- env_pace=1 -> env_step one cycle after every env_clk; dac_on dropped -> ch1_active 0 next edge; trig with dac_on=0 -> ch1_restart pulses, ch1_active stays 0.
- Active channel, sweep_ovf=1 -> ch1_active 0 next edge; sweep_ovf and ch1_restart in the same cycle with dac_on=1 -> ch1_active stays 1.
